global_fsm_task_sequencer: RTL and testbench

Top-level global FSM for a TAPA-style task graph. It accepts a host ap_start/ap_done handshake, latches the run scalars, and broadcasts them to every per-task FSM. It pulses start to all per-task FSMs, waits for all their is_done flags, then pulses a global done so they return to idle. It repeats this for a host-programmed iteration count and keeps cycle, iteration and timeout status.

---
 rtl/global_fsm_pkg.sv | 15 +
 rtl/global_fsm_task_sequencer_if.sv | 40 ++++
 rtl/global_fsm_task_sequencer_sat_counter.sv | 35 +++
 rtl/global_fsm_task_sequencer.sv | 123 ++++++++++++
 tb/tb_global_fsm_task_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/global_fsm_pkg.sv
// Shared types for the global task-graph FSM: state enum and its encoding width.
package global_fsm_pkg;

    localparam int unsigned STATE_W = 3;

    // Binary codes 5..7 are unused and recover to IDLE in the next-state logic.
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        RELEASE = 3'd3,
        FINISH  = 3'd4
    } state_e;

endpackage

// File: rtl/global_fsm_task_sequencer_if.sv
// Host handshake, run scalars and per-task broadcast/collect signals of the global FSM.
interface global_fsm_task_sequencer_if #(
    parameter int unsigned N_TASKS = 4,
    parameter int unsigned ITER_W  = 16,
    parameter int unsigned CYC_W   = 32
);
    logic                host_ap_start;
    logic                host_ap_ready;
    logic                host_ap_done;
    logic                host_ap_idle;
    logic [63:0]         host_s_input_mmap_offset;
    logic [31:0]         host_s_seq_len;
    logic [ITER_W-1:0]   host_s_num_iters;
    logic [63:0]         global_fsm_s_input_mmap_offset;
    logic [31:0]         global_fsm_s_seq_len;
    logic                global_fsm_ap_start;
    logic                global_fsm_ap_done;
    logic [N_TASKS-1:0]  task_is_done;
    logic [N_TASKS-1:0]  done_mask;
    logic [ITER_W-1:0]   iter_count;
    logic [CYC_W-1:0]    cycle_count;
    logic                timeout_err;

    modport master (
        output host_ap_start, host_s_input_mmap_offset, host_s_seq_len, host_s_num_iters,
               task_is_done,
        input  host_ap_ready, host_ap_done, host_ap_idle, global_fsm_s_input_mmap_offset,
               global_fsm_s_seq_len, global_fsm_ap_start, global_fsm_ap_done, done_mask,
               iter_count, cycle_count, timeout_err
    );

    modport slave (
        input  host_ap_start, host_s_input_mmap_offset, host_s_seq_len, host_s_num_iters,
               task_is_done,
        output host_ap_ready, host_ap_done, host_ap_idle, global_fsm_s_input_mmap_offset,
               global_fsm_s_seq_len, global_fsm_ap_start, global_fsm_ap_done, done_mask,
               iter_count, cycle_count, timeout_err
    );

endinterface

// File: rtl/global_fsm_task_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q, value_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i && (value_q != '1)) begin
            value_d = value_q + W'(1);
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/global_fsm_task_sequencer.sv
// Global FSM for a task graph: accepts a host run, broadcasts latched scalars and
// sequences start/done pulses to every per-task FSM for num_iters iterations.
module global_fsm_task_sequencer
    import global_fsm_pkg::*;
#(
    parameter int unsigned N_TASKS        = 4,
    parameter int unsigned ITER_W         = 16,
    parameter int unsigned CYC_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    global_fsm_task_sequencer_if.slave bus
);

    localparam logic [CYC_W-1:0] TIMEOUT_LAST =
        CYC_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [63:0]        offset_q, offset_d;
    logic [31:0]        seq_len_q, seq_len_d;
    logic [ITER_W-1:0]  num_iters_q, num_iters_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               timeout_q, timeout_d;
    logic [N_TASKS-1:0] done_mask_q;
    logic [ITER_W:0]    iter_inc;
    logic [CYC_W-1:0]   wait_timer;
    logic               accept, timer_clr, all_done;

    assign all_done = &bus.task_is_done;
    assign iter_inc = {1'b0, iter_q} + (ITER_W + 1)'(1);

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        seq_len_d   = seq_len_q;
        num_iters_d = num_iters_q;
        iter_d      = iter_q;
        timeout_d   = timeout_q;
        accept      = 1'b0;
        timer_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.host_ap_start) begin
                    accept      = 1'b1;
                    offset_d    = bus.host_s_input_mmap_offset;
                    seq_len_d   = bus.host_s_seq_len;
                    num_iters_d = bus.host_s_num_iters;
                    iter_d      = '0;
                    timeout_d   = 1'b0;
                    state_d     = (bus.host_s_num_iters == '0) ? FINISH : START;
                end
            end
            START: begin
                timer_clr = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                // Raw inputs: every task must report done in the same cycle.
                if (all_done) begin
                    state_d = RELEASE;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_timer == TIMEOUT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
            end
            RELEASE: begin
                iter_d  = iter_inc[ITER_W-1:0];
                state_d = (iter_inc < {1'b0, num_iters_q}) ? START : FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            seq_len_q   <= '0;
            num_iters_q <= '0;
            iter_q      <= '0;
            timeout_q   <= 1'b0;
            done_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            seq_len_q   <= seq_len_d;
            num_iters_q <= num_iters_d;
            iter_q      <= iter_d;
            timeout_q   <= timeout_d;
            done_mask_q <= bus.task_is_done;
        end
    end

    sat_counter #(.W(CYC_W)) u_cycle_cnt (
        .clk_i   (ap_clk),
        .rst_i   (ap_rst),
        .clr_i   (accept),
        .inc_i   (state_q inside {START, WAIT, RELEASE, FINISH}),
        .value_o (bus.cycle_count)
    );

    sat_counter #(.W(CYC_W)) u_wait_timer (
        .clk_i   (ap_clk),
        .rst_i   (ap_rst),
        .clr_i   (timer_clr),
        .inc_i   (state_q == WAIT),
        .value_o (wait_timer)
    );

    assign bus.host_ap_idle                   = (state_q == IDLE);
    assign bus.host_ap_ready                  = accept;
    assign bus.host_ap_done                   = (state_q == FINISH);
    assign bus.global_fsm_ap_start            = (state_q == START);
    assign bus.global_fsm_ap_done             = (state_q == RELEASE);
    assign bus.global_fsm_s_input_mmap_offset = offset_q;
    assign bus.global_fsm_s_seq_len           = seq_len_q;
    assign bus.done_mask                      = done_mask_q;
    assign bus.iter_count                     = iter_q;
    assign bus.timeout_err                    = timeout_q;

endmodule

// File: tb/tb_global_fsm_task_sequencer.sv
// Self-checking bench: per-task responders with programmed delays, run-level reference model.
module tb_global_fsm_task_sequencer;

    localparam int unsigned N_TASKS        = 4;
    localparam int unsigned ITER_W         = 16;
    localparam int unsigned CYC_W          = 32;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned MAX_IT         = 8;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    global_fsm_task_sequencer_if #(.N_TASKS(N_TASKS), .ITER_W(ITER_W), .CYC_W(CYC_W)) bus ();

    global_fsm_task_sequencer #(
        .N_TASKS(N_TASKS), .ITER_W(ITER_W), .CYC_W(CYC_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-iteration task delays in cycles after the start pulse; 0 means the task never finishes.
    int unsigned        dly_tab [MAX_IT][N_TASKS];
    logic [N_TASKS-1:0] resp_done;
    logic [N_TASKS-1:0] man_done;
    bit                 manual;

    assign bus.task_is_done = manual ? man_done : resp_done;

    // Task FSM responders: done goes high d cycles after start and drops on release/finish/reset.
    initial begin
        int unsigned cnt [N_TASKS];
        int unsigned start_idx;
        bit armed;
        resp_done = '0;
        armed     = 1'b0;
        start_idx = 0;
        forever begin
            @(posedge ap_clk);
            #2;
            if (bus.host_ap_ready) start_idx = 0;
            if (ap_rst || bus.host_ap_done || bus.global_fsm_ap_done) begin
                resp_done = '0;
                armed     = 1'b0;
            end else if (bus.global_fsm_ap_start) begin
                armed     = 1'b1;
                resp_done = '0;
                for (int i = 0; i < N_TASKS; i++) cnt[i] = dly_tab[start_idx][i];
                if (start_idx < MAX_IT - 1) start_idx++;
            end else if (armed) begin
                for (int i = 0; i < N_TASKS; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) resp_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Pulse and stability monitor; tests compare differences of these running totals.
    int unsigned mon_ready = 0, mon_gstart = 0, mon_gdone = 0, mon_hdone = 0;
    int unsigned mon_bad_release = 0, mon_scalar_chg = 0;
    initial begin
        bit          prev_all = 1'b0, prev2_all = 1'b0, prev_run = 1'b0;
        logic [31:0] prev_sl  = '0;
        logic [63:0] prev_off = '0;
        forever begin
            @(negedge ap_clk);
            if (bus.host_ap_ready)       mon_ready++;
            if (bus.global_fsm_ap_start) mon_gstart++;
            if (bus.global_fsm_ap_done)  mon_gdone++;
            if (bus.host_ap_done)        mon_hdone++;
            if (bus.global_fsm_ap_done && !(prev_all && !prev2_all)) mon_bad_release++;
            if (prev_run && !bus.host_ap_idle &&
                ((bus.global_fsm_s_seq_len != prev_sl) ||
                 (bus.global_fsm_s_input_mmap_offset != prev_off))) mon_scalar_chg++;
            prev2_all = prev_all;
            prev_all  = &bus.task_is_done;
            prev_run  = !bus.host_ap_idle;
            prev_sl   = bus.global_fsm_s_seq_len;
            prev_off  = bus.global_fsm_s_input_mmap_offset;
        end
    end

    task automatic do_run(input string name, input int unsigned n, input logic [63:0] off,
                          input logic [31:0] sl, input logic [31:0] post_sl);
        int unsigned exp_iters = 0, exp_cyc = 0, exp_gstart = 0, maxd, guard;
        bit exp_to = 1'b0, never;
        int unsigned s_ready, s_gstart, s_gdone, s_hdone, s_bad, s_chg;
        // Reference: each iteration costs START + slowest task + RELEASE, unless it times out.
        for (int k = 0; k < int'(n) && !exp_to; k++) begin
            maxd  = 0;
            never = 1'b0;
            for (int i = 0; i < N_TASKS; i++) begin
                if (dly_tab[k][i] == 0) never = 1'b1;
                else if (dly_tab[k][i] > maxd) maxd = dly_tab[k][i];
            end
            exp_gstart++;
            if (never || maxd > TIMEOUT_CYCLES) begin
                exp_to  = 1'b1;
                exp_cyc += 1 + TIMEOUT_CYCLES;
            end else begin
                exp_cyc += maxd + 2;
                exp_iters++;
            end
        end
        exp_cyc += 1;
        s_ready = mon_ready; s_gstart = mon_gstart; s_gdone = mon_gdone;
        s_hdone = mon_hdone; s_bad = mon_bad_release; s_chg = mon_scalar_chg;

        @(posedge ap_clk); #1;
        bus.host_ap_start            = 1'b1;
        bus.host_s_input_mmap_offset = off;
        bus.host_s_seq_len           = sl;
        bus.host_s_num_iters         = ITER_W'(n);
        @(negedge ap_clk);
        n_tests++; if (bus.host_ap_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_on_accept: got %b want 1", name, bus.host_ap_ready); end
        @(posedge ap_clk); #1;
        bus.host_ap_start            = 1'b0;
        bus.host_s_seq_len           = post_sl;
        bus.host_s_input_mmap_offset = ~off;
        bus.host_s_num_iters         = ITER_W'(n + 1);
        @(negedge ap_clk);
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL %s timeout_cleared: got %b want 0", name, bus.timeout_err); end
        n_tests++; if (bus.cycle_count !== '0) begin n_fail++; $display("FAIL %s cycle_cleared: got %0d want 0", name, bus.cycle_count); end
        n_tests++; if (bus.global_fsm_s_seq_len !== sl) begin n_fail++; $display("FAIL %s seq_len_latched: got %0d want %0d", name, bus.global_fsm_s_seq_len, sl); end
        guard = 0;
        while (bus.host_ap_done !== 1'b1 && guard < 3000) begin
            @(negedge ap_clk);
            guard++;
        end
        n_tests++; if (guard >= 3000) begin n_fail++; $display("FAIL %s host_done_wait: got no done after %0d cycles want done", name, guard); end
        @(negedge ap_clk);
        n_tests++; if (bus.host_ap_idle !== 1'b1) begin n_fail++; $display("FAIL %s idle_after: got %b want 1", name, bus.host_ap_idle); end
        n_tests++; if (bus.iter_count !== ITER_W'(exp_iters)) begin n_fail++; $display("FAIL %s iter_count: got %0d want %0d", name, bus.iter_count, exp_iters); end
        n_tests++; if (bus.cycle_count !== CYC_W'(exp_cyc)) begin n_fail++; $display("FAIL %s cycle_count: got %0d want %0d", name, bus.cycle_count, exp_cyc); end
        n_tests++; if (bus.timeout_err !== exp_to) begin n_fail++; $display("FAIL %s timeout_err: got %b want %b", name, bus.timeout_err, exp_to); end
        n_tests++; if (bus.global_fsm_s_input_mmap_offset !== off) begin n_fail++; $display("FAIL %s offset_held: got %h want %h", name, bus.global_fsm_s_input_mmap_offset, off); end
        n_tests++; if (mon_ready - s_ready !== 1) begin n_fail++; $display("FAIL %s ready_pulses: got %0d want 1", name, mon_ready - s_ready); end
        n_tests++; if (mon_gstart - s_gstart !== exp_gstart) begin n_fail++; $display("FAIL %s task_start_pulses: got %0d want %0d", name, mon_gstart - s_gstart, exp_gstart); end
        n_tests++; if (mon_gdone - s_gdone !== exp_iters) begin n_fail++; $display("FAIL %s task_done_pulses: got %0d want %0d", name, mon_gdone - s_gdone, exp_iters); end
        n_tests++; if (mon_hdone - s_hdone !== 1) begin n_fail++; $display("FAIL %s host_done_pulses: got %0d want 1", name, mon_hdone - s_hdone); end
        n_tests++; if (mon_bad_release - s_bad !== 0) begin n_fail++; $display("FAIL %s release_timing: got %0d late releases want 0", name, mon_bad_release - s_bad); end
        n_tests++; if (mon_scalar_chg - s_chg !== 0) begin n_fail++; $display("FAIL %s scalar_stable: got %0d changes want 0", name, mon_scalar_chg - s_chg); end
    endtask

    task automatic set_delays(input int unsigned k, input int unsigned d0, input int unsigned d1,
                              input int unsigned d2, input int unsigned d3);
        dly_tab[k][0] = d0; dly_tab[k][1] = d1; dly_tab[k][2] = d2; dly_tab[k][3] = d3;
    endtask

    task automatic test_reset();
        bus.host_ap_start = 1'b0; bus.host_s_input_mmap_offset = '0;
        bus.host_s_seq_len = '0;  bus.host_s_num_iters = '0;
        manual = 1'b0; man_done = '0; ap_rst = 1'b1;
        repeat (3) @(negedge ap_clk);
        n_tests++; if (bus.host_ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset idle: got %b want 1", bus.host_ap_idle); end
        n_tests++; if ({bus.host_ap_ready, bus.host_ap_done, bus.global_fsm_ap_start, bus.global_fsm_ap_done, bus.timeout_err} !== 5'b0)
            begin n_fail++; $display("FAIL reset pulses: got %b want 00000", {bus.host_ap_ready, bus.host_ap_done, bus.global_fsm_ap_start, bus.global_fsm_ap_done, bus.timeout_err}); end
        n_tests++; if ({bus.iter_count, bus.cycle_count, bus.done_mask, bus.global_fsm_s_seq_len, bus.global_fsm_s_input_mmap_offset} !== '0)
            begin n_fail++; $display("FAIL reset state: got iter %0d cyc %0d mask %b sl %0d off %h want all 0", bus.iter_count, bus.cycle_count, bus.done_mask, bus.global_fsm_s_seq_len, bus.global_fsm_s_input_mmap_offset); end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
    endtask

    task automatic test_single_iter();
        set_delays(0, 5, 5, 5, 5);
        do_run("single_iter", 1, 64'h1000_0000_0000_0040, 32'd64, 32'd64);
    endtask

    task automatic test_staggered();
        for (int k = 0; k < 3; k++) set_delays(k, 2, 7, 4, 9);
        do_run("staggered", 3, 64'h0000_0000_dead_0000, 32'd512, 32'd512);
    endtask

    task automatic test_zero_iters();
        do_run("zero_iters", 0, 64'h55, 32'd7, 32'd9);
    endtask

    task automatic test_timeout();
        set_delays(0, 3, 5, 2, 0);
        do_run("timeout", 2, 64'h77, 32'd3, 32'd3);
        set_delays(0, 1, 1, 1, 1);
        do_run("after_timeout", 1, 64'h78, 32'd4, 32'd4);
    endtask

    task automatic test_scalar_hold();
        for (int k = 0; k < 2; k++) set_delays(k, 3, 6, 1, 8);
        do_run("seq_len_hold", 2, 64'h100, 32'd128, 32'd256);
        do_run("seq_len_next", 1, 64'h200, 32'd256, 32'd256);
    endtask

    task automatic test_reset_mid_run();
        int unsigned guard = 0, s_hdone;
        set_delays(0, 12, 12, 12, 12);
        @(posedge ap_clk); #1;
        bus.host_ap_start = 1'b1; bus.host_s_num_iters = ITER_W'(2);
        bus.host_s_seq_len = 32'd99; bus.host_s_input_mmap_offset = 64'h99;
        @(posedge ap_clk); #1;
        bus.host_ap_start = 1'b0;
        while (bus.global_fsm_ap_start !== 1'b1 && guard < 50) begin @(negedge ap_clk); guard++; end
        n_tests++; if (guard >= 50) begin n_fail++; $display("FAIL rst_mid task_start_wait: got none want pulse"); end
        repeat (3) @(negedge ap_clk);
        s_hdone = mon_hdone;
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        n_tests++; if (bus.host_ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_mid idle: got %b want 1", bus.host_ap_idle); end
        n_tests++; if ({bus.host_ap_ready, bus.host_ap_done, bus.global_fsm_ap_start, bus.global_fsm_ap_done, bus.timeout_err,
                        bus.iter_count, bus.cycle_count, bus.done_mask, bus.global_fsm_s_seq_len, bus.global_fsm_s_input_mmap_offset} !== '0)
            begin n_fail++; $display("FAIL rst_mid outputs: got iter %0d cyc %0d mask %b sl %0d want all 0", bus.iter_count, bus.cycle_count, bus.done_mask, bus.global_fsm_s_seq_len); end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        repeat (4) @(negedge ap_clk);
        n_tests++; if (mon_hdone != s_hdone) begin n_fail++; $display("FAIL rst_mid no_done: got %0d pulses want 0", mon_hdone - s_hdone); end
        set_delays(0, 2, 3, 1, 2);
        do_run("after_rst", 1, 64'h1234, 32'd16, 32'd17);
    endtask

    task automatic test_done_drop();
        logic [N_TASKS-1:0] pats [4];
        int unsigned guard = 0;
        pats[0] = 4'b0111; pats[1] = 4'b1110; pats[2] = 4'b1011; pats[3] = 4'b1111;
        manual = 1'b1; man_done = '0;
        @(posedge ap_clk); #1;
        bus.host_ap_start = 1'b1; bus.host_s_num_iters = ITER_W'(1);
        @(posedge ap_clk); #1;
        bus.host_ap_start = 1'b0;
        @(negedge ap_clk);
        n_tests++; if (bus.global_fsm_ap_start !== 1'b1) begin n_fail++; $display("FAIL drop start_pulse: got %b want 1", bus.global_fsm_ap_start); end
        for (int j = 0; j < 4; j++) begin
            @(posedge ap_clk); #1;
            man_done = pats[j];
            @(negedge ap_clk);
            n_tests++; if (bus.global_fsm_ap_done !== 1'b0) begin n_fail++; $display("FAIL drop early_release step %0d: got %b want 0", j, bus.global_fsm_ap_done); end
            if (j > 0) begin
                n_tests++; if (bus.done_mask !== pats[j-1]) begin n_fail++; $display("FAIL drop done_mask step %0d: got %b want %b", j, bus.done_mask, pats[j-1]); end
            end
        end
        @(posedge ap_clk); #1;
        man_done = '0;
        @(negedge ap_clk);
        n_tests++; if (bus.global_fsm_ap_done !== 1'b1) begin n_fail++; $display("FAIL drop release: got %b want 1", bus.global_fsm_ap_done); end
        n_tests++; if (bus.done_mask !== 4'b1111) begin n_fail++; $display("FAIL drop final_mask: got %b want 1111", bus.done_mask); end
        while (bus.host_ap_done !== 1'b1 && guard < 20) begin @(negedge ap_clk); guard++; end
        n_tests++; if (guard >= 20) begin n_fail++; $display("FAIL drop host_done_wait: got none want pulse"); end
        @(negedge ap_clk);
        n_tests++; if (bus.iter_count !== ITER_W'(1)) begin n_fail++; $display("FAIL drop iter_count: got %0d want 1", bus.iter_count); end
        manual = 1'b0;
    endtask

    task automatic test_random();
        int unsigned n;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < int'(MAX_IT); k++)
                for (int i = 0; i < N_TASKS; i++) dly_tab[k][i] = $urandom_range(1, TIMEOUT_CYCLES + 1);
            do_run($sformatf("random_%0d", r), n, {$urandom, $urandom}, $urandom, $urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset();
        test_single_iter();
        test_staggered();
        test_zero_iters();
        test_timeout();
        test_scalar_hold();
        test_done_drop();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
